// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the writable program store of the Aeolus CPU.
//   loader_state_t       run/load sequencer states (IDLE=0, CLEAR=1, LOAD=2, RUN=3)
//   FILL_OPCODE_DEFAULT  opcode swept into memory during CLEAR; it is the same
//                        value the instruction decoder treats as a no-op.
// ---------------------------------------------------------------------------
package program_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } loader_state_t;

    localparam logic [3:0] FILL_OPCODE_DEFAULT = 4'h0;

endpackage

// File: rtl/program_ram.sv
// ---------------------------------------------------------------------------
// program_ram
// 2^ADDR_WIDTH x DATA_WIDTH program memory. Synchronous write, asynchronous
// read so the CPU fetch path behaves exactly like the ROM it replaces.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (CPU program counter)
//   rdata  out  combinational read data
// The array has no reset: contents survive a reset of the loader.
// ---------------------------------------------------------------------------
module program_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Writable program store filled from the board switches. A run/load FSM
// clears the memory, accepts one word per rising edge of the debounced write
// strobe, and holds the CPU in reset until the user switches back to run.
// Integration: CPU reset = reset | cpuHold; readAddr/readData replace the ROM.
// Ports:
//   clk          in   system clock (divided CPU clock)
//   reset        in   synchronous, active-high
//   loadMode     in   1 = request load, 0 = request run
//   writeStrobe  in   debounced push-button level, one write per rising edge
//   dataIn       in   opcode to write
//   readAddr     in   CPU fetch address
//   readData     out  opcode at readAddr (combinational)
//   cpuHold      out  registered, high whenever the FSM is not in RUN
//   loadAddr     out  registered, next write address
//   progLength   out  registered, words written since the last CLEAR
//   full         out  registered, progLength == 2^ADDR_WIDTH
//   clearing     out  registered, high during the CLEAR sweep
// ---------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] FILL_OPCODE = DATA_WIDTH'(FILL_OPCODE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  loadMode,
    input  logic                  writeStrobe,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  cpuHold,
    output logic [ADDR_WIDTH-1:0] loadAddr,
    output logic [ADDR_WIDTH:0]   progLength,
    output logic                  full,
    output logic                  clearing
);

    // Length value whose increment makes the store full.
    localparam logic [ADDR_WIDTH:0] LAST_LEN = (ADDR_WIDTH+1)'((2**ADDR_WIDTH) - 1);

    loader_state_t         state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic                  strobe_prev;
    logic                  strobe_edge;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    assign strobe_edge = writeStrobe & ~strobe_prev;

    // Write-port mux: the sweep counter owns the port during CLEAR, the load
    // pointer during LOAD. Reset blocks the write so an interrupted sweep
    // leaves memory exactly as far as it had got.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = loadAddr;
        ram_wdata = dataIn;
        if (!reset) begin
            case (state)
                ST_CLEAR: begin
                    ram_we    = 1'b1;
                    ram_waddr = sweep_cnt;
                    ram_wdata = FILL_OPCODE;
                end
                ST_LOAD: begin
                    ram_we = strobe_edge & ~full;
                end
                default: begin
                    ram_we = 1'b0;
                end
            endcase
        end
    end

    // Run/load sequencer. All outputs are registered from the next state so
    // cpuHold and clearing change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cpuHold     <= 1'b1;
            loadAddr    <= '0;
            progLength  <= '0;
            full        <= 1'b0;
            clearing    <= 1'b0;
            strobe_prev <= 1'b0;
            sweep_cnt   <= '0;
        end else begin
            strobe_prev <= writeStrobe;
            case (state)
                ST_IDLE: begin
                    if (loadMode) begin
                        state     <= ST_CLEAR;
                        sweep_cnt <= '0;
                        clearing  <= 1'b1;
                    end else begin
                        state   <= ST_RUN;
                        cpuHold <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // loadMode and strobes are ignored until the sweep ends.
                    if (sweep_cnt == '1) begin
                        state      <= ST_LOAD;
                        clearing   <= 1'b0;
                        loadAddr   <= '0;
                        progLength <= '0;
                        full       <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (strobe_edge && !full) begin
                        loadAddr   <= loadAddr + 1'b1;
                        progLength <= progLength + 1'b1;
                        full       <= (progLength == LAST_LEN);
                    end
                    // A strobe edge in the same cycle still commits above.
                    if (!loadMode) begin
                        state   <= ST_RUN;
                        cpuHold <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (loadMode) begin
                        state     <= ST_CLEAR;
                        sweep_cnt <= '0;
                        clearing  <= 1'b1;
                        cpuHold   <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cpuHold <= 1'b1;
                end
            endcase
        end
    end

    program_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (readAddr),
        .rdata (readData)
    );

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Scoreboard bench: after every clock edge the stimulus side advances a
// behavioural model of the loader and queues the outputs it expects; a
// monitor on the falling edge pops each entry and compares it to the DUT.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int AW    = 8;
    localparam int DW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_r;
    logic          load_mode;
    logic          write_strobe;
    logic [DW-1:0] data_in;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data;
    logic          cpu_hold;
    logic [AW-1:0] load_addr;
    logic [AW:0]   prog_length;
    logic          full;
    logic          clearing;

    always #5 clk = ~clk;

    program_loader dut (
        .clk         (clk),
        .reset       (reset_r),
        .loadMode    (load_mode),
        .writeStrobe (write_strobe),
        .dataIn      (data_in),
        .readAddr    (read_addr),
        .readData    (read_data),
        .cpuHold     (cpu_hold),
        .loadAddr    (load_addr),
        .progLength  (prog_length),
        .full        (full),
        .clearing    (clearing)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    // Mode names of the model itself; it works from the behaviour rules only.
    localparam int M_IDLE = 0, M_CLEAR = 1, M_LOAD = 2, M_RUN = 3;

    int m_mode, m_sweep, m_addr, m_len;
    bit m_hold, m_full, m_clr, m_prev;
    int m_mem   [DEPTH];
    bit m_known [DEPTH];

    function automatic void model_step();
        bit edge_seen;
        if (reset_r) begin
            m_mode = M_IDLE; m_hold = 1; m_addr = 0; m_len = 0;
            m_full = 0; m_clr = 0; m_prev = 0;
            return;
        end
        edge_seen = write_strobe && !m_prev;
        m_prev    = write_strobe;
        case (m_mode)
            M_IDLE: begin
                if (load_mode) begin m_mode = M_CLEAR; m_sweep = 0; m_clr = 1; end
                else begin m_mode = M_RUN; m_hold = 0; end
            end
            M_CLEAR: begin
                m_mem[m_sweep] = 0; m_known[m_sweep] = 1;
                if (m_sweep == DEPTH - 1) begin
                    m_mode = M_LOAD; m_clr = 0; m_addr = 0; m_len = 0; m_full = 0;
                end else begin
                    m_sweep++;
                end
            end
            M_LOAD: begin
                if (edge_seen && !m_full) begin
                    m_mem[m_addr] = int'(data_in); m_known[m_addr] = 1;
                    m_addr = (m_addr + 1) % DEPTH;
                    m_len++;
                    m_full = (m_len == DEPTH);
                end
                if (!load_mode) begin m_mode = M_RUN; m_hold = 0; end
            end
            default: begin
                if (load_mode) begin m_mode = M_CLEAR; m_sweep = 0; m_clr = 1; m_hold = 1; end
            end
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int hold, la, len, fl, clr, ra, rd;
        bit rd_known;
    } exp_t;

    exp_t exp_q[$];

    function automatic void push_exp();
        exp_t e;
        e.hold = m_hold; e.la = m_addr; e.len = m_len; e.fl = m_full; e.clr = m_clr;
        e.ra = int'(read_addr);
        e.rd = m_mem[read_addr];
        e.rd_known = m_known[read_addr];
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cpuHold",    32'(cpu_hold),    32'(e.hold));
                chk("loadAddr",   32'(load_addr),   32'(e.la));
                chk("progLength", 32'(prog_length), 32'(e.len));
                chk("full",       32'(full),        32'(e.fl));
                chk("clearing",   32'(clearing),    32'(e.clr));
                if (e.rd_known)
                    chk($sformatf("readData[%0d]", e.ra), 32'(read_data), 32'(e.rd));
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rand_ra = 1;

    task automatic tick();
        if (rand_ra) read_addr = AW'($urandom);
        @(posedge clk);
        model_step();
        push_exp();
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DW-1:0] d, input int hi, input int lo);
        data_in = d;
        write_strobe = 1;
        repeat (hi) tick();
        write_strobe = 0;
        repeat (lo) tick();
    endtask

    // Full clear sweep from IDLE or RUN: one entry tick plus DEPTH sweep ticks.
    task automatic do_clear();
        load_mode = 1;
        repeat (DEPTH + 1) tick();
    endtask

    task automatic seed_all_f();
        do_clear();
        for (int i = 0; i < DEPTH; i++) strobe(4'hF, 1, 1);
        load_mode = 0;
        repeat (2) tick();
    endtask

    task automatic read_at(input int a);
        rand_ra = 0;
        read_addr = AW'(a);
        tick();
        rand_ra = 1;
    endtask

    initial begin : stim
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_known[i] = 0; end
        m_mode = M_IDLE; m_sweep = 0; m_addr = 0; m_len = 0;
        m_hold = 1; m_full = 0; m_clr = 0; m_prev = 0;

        reset_r = 1; load_mode = 0; write_strobe = 0; data_in = '0; read_addr = '0;
        repeat (3) tick();

        // Seed memory with 4'hF, fill to full, then a 257th strobe is refused.
        reset_r = 0;
        seed_all_f();
        load_mode = 1;
        repeat (DEPTH + 1) tick();
        for (int i = 0; i < DEPTH; i++) strobe(4'hF, $urandom_range(1, 3), 1);
        strobe(4'h5, 2, 1);
        read_at(0);
        load_mode = 0;
        repeat (3) tick();

        // Clear with a strobe pulse at CLEAR cycle 50, then sweep every address.
        load_mode = 1;
        repeat (51) tick();
        data_in = 4'h9;
        write_strobe = 1; repeat (3) tick(); write_strobe = 0;
        repeat (DEPTH - 54 + 1) tick();
        for (int i = 0; i < DEPTH; i++) read_at(i);

        // Three words with the strobe held for five cycles each.
        strobe(4'h1, 5, 2);
        strobe(4'h3, 5, 2);
        strobe(4'hA, 5, 2);
        for (int i = 0; i < 4; i++) read_at(i);

        // Run request in the same cycle as a strobe edge still writes.
        data_in = 4'h7; write_strobe = 1; load_mode = 0;
        tick();
        write_strobe = 0;
        tick();
        read_at(3);

        // Random load session.
        do_clear();
        for (int i = 0; i < 40; i++)
            strobe(DW'($urandom), $urandom_range(1, 4), $urandom_range(1, 3));
        load_mode = 0;
        for (int i = 0; i < 42; i++) read_at(i);

        // Reset during CLEAR cycle 100 leaves the sweep partial.
        seed_all_f();
        load_mode = 1;
        repeat (101) tick();
        reset_r = 1;
        tick();
        read_at(99);
        read_at(100);
        read_at(200);
        reset_r = 0; load_mode = 0;
        repeat (2) tick();

        @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
